usr_ser_ctrl: RTL and testbench

- Sequencing controller for an n-bit universal shift register (sel: 00 hold, 01 load, 10 shift left, 11 shift right).
- On a start request it loads the register, then shifts it out one bit per programmable bit period, MSB-first or LSB-first.
- Presents the outgoing serial bit and a busy/done handshake to the requester.
- Sits beside the shift register: it drives that register's sel and dbit, and observes that register's two end bits.

---
 rtl/usr_ser_ctrl_if.sv | 28 ++
 rtl/usr_ser_ctrl.sv | 96 +++++++++
 tb/tb_usr_ser_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usr_ser_ctrl_if.sv
// Requester / shift-register side signals of the usr_ser_ctrl sequencer.
// The master drives requests and the register end bits; the slave is the controller.
interface usr_ser_ctrl_if #(
  parameter int DW = 16
);
  logic          start;
  logic          stop;
  logic          dir;
  logic [DW-1:0] div;
  logic          fill;
  logic          usr_msb;
  logic          usr_lsb;
  logic [1:0]    sel;
  logic          dbit;
  logic          ser_out;
  logic          busy;
  logic          done;

  modport master (
    output start, stop, dir, div, fill, usr_msb, usr_lsb,
    input  sel, dbit, ser_out, busy, done
  );

  modport slave (
    input  start, stop, dir, div, fill, usr_msb, usr_lsb,
    output sel, dbit, ser_out, busy, done
  );
endinterface

// File: rtl/usr_ser_ctrl.sv
// Load-then-shift-out sequencer for an N-bit universal shift register.
// Define USR_SER_CTRL_ROT_EN to feed the outgoing bit back in (rotate) instead of fill.
//
// state | meaning
// IDLE  | waiting for start, register held
// LOAD  | sel=01, register captures parallel data on the next edge
// BIT   | sel=00, hold the current bit for div_l cycles
// SHIFT | sel=10/11, advance the register by one bit
// DONE  | one-cycle done pulse
module usr_ser_ctrl #(
  parameter int N  = 8,
  parameter int DW = 16
) (
  input  logic         clk,
  input  logic         clr,
  usr_ser_ctrl_if.slave bus
);
  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST = BW'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, BIT, SHIFT, DONE} state_t;

  state_t        state, nxt;
  logic          dir_l;
  logic [DW-1:0] div_l;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [1:0]    sel;
  logic          busy, done;
  logic          src_bit;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dir_l   <= 1'b0;
      div_l   <= DW'(1);
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == IDLE && bus.start && !bus.stop) begin
        dir_l <= bus.dir;
        div_l <= (bus.div == '0) ? DW'(1) : bus.div;
      end
      if (bus.stop || state == LOAD || state == SHIFT) div_cnt <= '0;
      else if (state == BIT)                           div_cnt <= div_cnt + DW'(1);
      if (bus.stop || state == LOAD) bit_cnt <= '0;
      else if (state == SHIFT)       bit_cnt <= bit_cnt + BW'(1);
    end
  end

  always_comb begin
    nxt  = state;
    sel  = 2'b00;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE:  if (bus.start) nxt = LOAD;
      LOAD: begin
        sel  = 2'b01;
        busy = 1'b1;
        nxt  = BIT;
      end
      BIT: begin
        busy = 1'b1;
        if (div_cnt == div_l - DW'(1)) nxt = SHIFT;
      end
      SHIFT: begin
        sel  = {1'b1, dir_l};
        busy = 1'b1;
        nxt  = (bit_cnt == LAST) ? DONE : BIT;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // abort wins over everything, including a start seen in IDLE
    if (bus.stop) nxt = IDLE;
  end

  assign src_bit     = dir_l ? bus.usr_lsb : bus.usr_msb;
  assign bus.sel     = sel;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.ser_out = (state == BIT || state == SHIFT) ? src_bit : 1'b0;
`ifdef USR_SER_CTRL_ROT_EN
  assign bus.dbit    = src_bit;
`else
  assign bus.dbit    = bus.fill;
`endif
endmodule

// File: tb/tb_usr_ser_ctrl.sv
// Scoreboard bench for usr_ser_ctrl with a behavioural universal shift register beside it.
module tb_usr_ser_ctrl;
  localparam int N  = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [N-1:0] r = '0;
  logic [N-1:0] din = '0;

  usr_ser_ctrl_if #(.DW(DW)) bus ();

  usr_ser_ctrl #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // the controlled universal shift register
  always @(posedge clk) begin
    case (bus.sel)
      2'b01:   r <= din;
      2'b10:   r <= {r[N-2:0], bus.dbit};
      2'b11:   r <= {bus.dbit, r[N-1:1]};
      default: r <= r;
    endcase
  end
  assign bus.usr_msb = r[N-1];
  assign bus.usr_lsb = r[0];

  typedef struct {
    int           cyc;
    logic [1:0]   sel;
    logic         busy;
    logic         done;
    logic         ser;
    logic         chk_reg;
    logic [N-1:0] regv;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic exp_t mk(int c, logic [1:0] s, logic b, logic d, logic o);
    exp_t e;
    e.cyc = c; e.sel = s; e.busy = b; e.done = d; e.ser = o;
    e.chk_reg = 1'b0; e.regv = '0;
    return e;
  endfunction

  // Expected cycle-by-cycle view of one transfer whose start is sampled at the end of cycle s.
  task automatic push_xfer(input int s, input logic [N-1:0] data, input logic d,
                           input int dv, input logic f);
    int   de;
    int   c;
    logic b;
    exp_t e;
    de = (dv == 0) ? 1 : dv;
    c  = s + 1;
    q.push_back(mk(c, 2'b01, 1'b1, 1'b0, 1'b0)); c++;
    for (int i = 0; i < N; i++) begin
      b = d ? data[i] : data[N-1-i];
      for (int k = 0; k < de; k++) begin
        q.push_back(mk(c, 2'b00, 1'b1, 1'b0, b)); c++;
      end
      q.push_back(mk(c, {1'b1, d}, 1'b1, 1'b0, b)); c++;
    end
    e = mk(c, 2'b00, 1'b0, 1'b1, 1'b0);
    e.chk_reg = 1'b1;
`ifdef USR_SER_CTRL_ROT_EN
    e.regv = data;
`else
    e.regv = {N{f}};
`endif
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!clr && (bus.busy || bus.done)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output at cycle %0d: busy=%0b done=%0b sel=%0d, expected idle",
                 cyc, bus.busy, bus.done, bus.sel);
      end else begin
        e = q.pop_front();
        checks++;
        if (cyc != e.cyc || bus.sel !== e.sel || bus.busy !== e.busy ||
            bus.done !== e.done || bus.ser_out !== e.ser) begin
          errors++;
          $display("FAIL trace: got cyc=%0d sel=%0d busy=%0b done=%0b ser=%0b, expected cyc=%0d sel=%0d busy=%0b done=%0b ser=%0b",
                   cyc, bus.sel, bus.busy, bus.done, bus.ser_out,
                   e.cyc, e.sel, e.busy, e.done, e.ser);
        end
        if (e.chk_reg) begin
          checks++;
          if (r !== e.regv) begin
            errors++;
            $display("FAIL final_reg at cycle %0d: got %02h, expected %02h", cyc, r, e.regv);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    int n = 0;
    while (cyc < c && n < 2000) begin tick(); n++; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 2000) begin tick(); n++; end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL timeout at cycle %0d: %0d expected outputs never seen, expected 0", cyc, q.size());
      q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic trim_from(input int c);
    while (q.size() > 0 && q[$].cyc >= c) void'(q.pop_back());
  endtask

  // drive one start pulse; after it, scramble dir/div to show they are latched
  task automatic xfer(input logic [N-1:0] data, input logic d, input int dv,
                      input logic f, output int s);
    din = data; bus.dir = d; bus.div = DW'(dv); bus.fill = f; bus.start = 1'b1;
    s = cyc;
    push_xfer(s, data, d, dv, f);
    tick();
    bus.start = 1'b0;
    bus.dir   = 1'($urandom);
    bus.div   = DW'($urandom_range(0, 9));
  endtask

  initial begin
    int s, s2, dv;
    logic [N-1:0] data;
    logic d, f;
    bus.start = 1'b0; bus.stop = 1'b0; bus.dir = 1'b0; bus.div = '0; bus.fill = 1'b1;
    #1;
    chk("reset_sel", bus.sel, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_ser", bus.ser_out, 0);
`ifndef USR_SER_CTRL_ROT_EN
    chk("reset_dbit", bus.dbit, 1);
    bus.fill = 1'b0; #1;
    chk("reset_dbit0", bus.dbit, 0);
`endif
    repeat (2) tick();
    #2 clr = 1'b0;
    repeat (2) tick();

    // MSB-first 0xA5, div=4, with a start pulse while busy in cycle 5
    xfer(8'hA5, 1'b0, 4, 1'b0, s);
    wait_until(s + 5);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_idle();

    // LSB-first 0x01, div=0 treated as 1, fill=1
    xfer(8'h01, 1'b1, 0, 1'b1, s);
    wait_idle();

    // stop in cycle 10, then stop+start together, then a clean restart
    xfer(8'hA5, 1'b0, 4, 1'b0, s);
    wait_until(s + 10);
    bus.stop = 1'b1;
    trim_from(s + 11);
    tick();
    chk("stop_sel", bus.sel, 0);
    chk("stop_busy", bus.busy, 0);
    chk("stop_done", bus.done, 0);
    bus.start = 1'b1;
    tick();
    chk("stop_start_idle", bus.busy, 0);
    bus.stop = 1'b0; bus.start = 1'b0;
    repeat (3) tick();
    xfer(8'h96, 1'b0, 2, 1'b1, s);
    wait_idle();

    // start held high: back-to-back transfers with one IDLE cycle between
    din = 8'h5C; bus.dir = 1'b1; bus.div = DW'(1); bus.fill = 1'b0; bus.start = 1'b1;
    s = cyc;
    push_xfer(s, 8'h5C, 1'b1, 1, 1'b0);
    s2 = s + 3 + N * 2;
    push_xfer(s2, 8'h5C, 1'b1, 1, 1'b0);
    wait_until(s2 + 2);
    bus.start = 1'b0;
    wait_idle();

    // asynchronous clr in the middle of a BIT period
    xfer(8'hC3, 1'b0, 4, 1'b0, s);
    wait_until(s + 4);
    #1 clr = 1'b1;
    trim_from(s + 4);
    #1;
    chk("clr_sel", bus.sel, 0);
    chk("clr_busy", bus.busy, 0);
    chk("clr_done", bus.done, 0);
    chk("clr_ser", bus.ser_out, 0);
    tick();
    #3 clr = 1'b0;
    repeat (3) tick();

    // 0x3C MSB-first (rotation restores it when the feature is built in)
    xfer(8'h3C, 1'b0, 1, 1'b0, s);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      data = N'($urandom);
      d    = 1'($urandom);
      dv   = $urandom_range(0, 4);
      f    = 1'($urandom);
      xfer(data, d, dv, f, s);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d: simulation did not finish, expected finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
